alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station for the integer ALU, directly downstream of `reg_file`. Each dispatched instruction arrives with per-operand (tag, value) pairs from the register file result interface. The station holds up to `ENTRIES` instructions and captures pending operands from the write-back broadcast. It issues the oldest fully-ready instruction to the ALU through a registered valid/ready output stage.

## Interface
- `DATA_W`, 32, operand/result width (matches `COMMON_WIDTH`)
- `TAG_W`, 4, instruction tag width (matches `INST_TAG_WIDTH`)
- `OP_W`, 5, ALU opcode width
- `ENTRIES`, 4, station depth, 2..8
- `clk` in 1, single clock; all state updates on posedge
- `rst` in 1, asynchronous, active-low reset
- `flush` in 1, synchronous clear of all entries and the issue register (mispredict)
- `in_valid` in 1, dispatch request
- `in_ready` out 1, station can accept a dispatch this cycle
- `in_op` in OP_W, ALU opcode
- `in_dest_tag` in TAG_W, tag of the dispatched instruction
- `in_tag1`, `in_tag2` in TAG_W, operand tags; all-ones (`TAG_INVALID`) means value present
- `in_val1`, `in_val2` in DATA_W, operand values, meaningful when the tag is `TAG_INVALID`
- `wb_valid` in 1, write-back broadcast valid
- `wb_tag` in TAG_W, broadcast tag
- `wb_data` in DATA_W, broadcast result
- `iss_valid` out 1, issue register holds an instruction
- `iss_ready` in 1, ALU accepts the instruction this cycle
- `iss_op` out OP_W, opcode of the issued instruction
- `iss_dest_tag` out TAG_W, destination tag of the issued instruction
- `iss_a`, `iss_b` out DATA_W, operand values of the issued instruction
- `count` out $clog2(ENTRIES+1), occupied entries, excluding the issue register

## Operation
- Each entry holds: busy, op, dest_tag, tag1/val1, tag2/val2, and an age relative to the other busy entries.
  - An entry is ready when busy and both tags equal `TAG_INVALID`.
- **Dispatch** happens when `in_valid && in_ready && !flush`.
  - The request writes the lowest-index free entry and makes it the youngest.
  - `in_ready = (count != ENTRIES)`. It does not depend on a same-cycle free.
- **Dispatch bypass** (always on): if `wb_valid` and `in_tagN == wb_tag` (with `in_tagN != TAG_INVALID`), operand N is written as `wb_data` with tag `TAG_INVALID`.
- **Wakeup**: every busy entry whose tagN is not `TAG_INVALID` and equals `wb_tag` while `wb_valid` latches `wb_data` into valN and sets tagN to `TAG_INVALID`.
  - Both operands may wake on the same broadcast.
- **Select/issue**: the issue register loads when `!iss_valid || iss_ready`.
  - It loads the oldest ready entry, frees that entry, and sets `iss_valid=1`.
  - If no entry is ready, `iss_valid` goes to 0.
  - Entries that stay busy keep their relative age order.
- **Simultaneous dispatch and free**: `count` is unchanged. The freed slot is not reusable in the same cycle.
- **Flush**: at the next edge, all busy bits clear, `iss_valid` becomes 0 and `count` becomes 0. A dispatch or wakeup in the same cycle is discarded.
- **Broadcast matching an issued instruction's own tag**: ignored; there is no self-wakeup hazard.

## Timing
- **Reset** (`rst`=0, asynchronous): all entries free; `iss_valid`=0; `iss_op`, `iss_dest_tag`, `iss_a`, `iss_b`=0; `count`=0; `in_ready`=1.
- **Dispatch with both operands ready**, written at edge E:
  - selectable at edge E+1;
  - `iss_valid`=1 from E+1 (two cycles from request to issue).
- **Operand woken at edge W**: selectable at edge W+1 (baseline).
- `iss_*` outputs are registered and hold stable while `iss_valid && !iss_ready`.
- Full-rate issue is one instruction per cycle when ready entries exist and `iss_ready`=1.

## Configuration
- `RS_FAST_WAKEUP_EN` defined:
  - An entry whose last pending operand matches the broadcast in cycle W is eligible for select at the same edge W.
  - `wb_data` is forwarded straight into `iss_a`/`iss_b`, so wakeup-to-issue takes one cycle.
  - Among candidates, the oldest still wins.
  - Dispatch itself is not fast-selected.
- `RS_FAST_WAKEUP_EN` undefined: select considers only entries already ready before the edge; wakeup-to-issue takes two cycles.

## Test plan
- **Reset and basic issue**:
  - Stimulus: hold `rst`=0, then release; dispatch op=3, dest=2, tag1=tag2=F, val1=5, val2=7; `iss_ready`=1.
  - Response: `iss_valid` rises two edges after the request with `iss_a`=5, `iss_b`=7, `iss_dest_tag`=2; `count` goes 1 then 0.
- **Wakeup**:
  - Stimulus: dispatch with tag1=4; one cycle later broadcast `wb_tag`=4, `wb_data`=0x1234.
  - Response: issue with `iss_a`=0x1234 one edge after the broadcast edge with `RS_FAST_WAKEUP_EN`, two edges without it.
- **Dispatch bypass**:
  - Stimulus: dispatch tag2=6 in the same cycle as `wb_valid`=1, `wb_tag`=6, `wb_data`=9.
  - Response: the entry is ready immediately and issues with `iss_b`=9, no further broadcast needed.
- **Full and backpressure**:
  - Stimulus: fill 4 entries with pending tags and hold `iss_ready`=0.
  - Response: `in_ready`=0 at `count`=4, and a fifth `in_valid` is ignored.
  - Stimulus: wake all four with a single broadcast.
  - Response: issue proceeds in dispatch order, and the `iss_*` outputs stay stable while stalled.
- **Age order**:
  - Stimulus: dispatch A (pending tag 1), B (ready), then wake A.
  - Response: B issues first; A issues after its wakeup.
- **Flush**:
  - Stimulus: with 3 busy entries and `iss_valid`=1, assert `flush` together with `in_valid`.
  - Response: next cycle `count`=0, `iss_valid`=0, `in_ready`=1, and the flushed dispatch never issues.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station for the integer ALU with operand wakeup and oldest-ready select.
// Optional macro RS_FAST_WAKEUP_EN: a broadcast can wake and select an entry at the same edge.
module alu_rs #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 5,
    parameter int ENTRIES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_op,
    input  logic [TAG_W-1:0]             in_dest_tag,
    input  logic [TAG_W-1:0]             in_tag1,
    input  logic [TAG_W-1:0]             in_tag2,
    input  logic [DATA_W-1:0]            in_val1,
    input  logic [DATA_W-1:0]            in_val2,
    input  logic                         wb_valid,
    input  logic [TAG_W-1:0]             wb_tag,
    input  logic [DATA_W-1:0]            wb_data,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [OP_W-1:0]              iss_op,
    output logic [TAG_W-1:0]             iss_dest_tag,
    output logic [DATA_W-1:0]            iss_a,
    output logic [DATA_W-1:0]            iss_b,
    output logic [$clog2(ENTRIES+1)-1:0] count
);
    localparam int CW = $clog2(ENTRIES+1);
    localparam int AW = $clog2(ENTRIES);
    localparam logic [TAG_W-1:0] TAG_INVALID = '1;

    // age = number of busy entries older than this one
    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [AW-1:0]     age;
    } entry_t;

    entry_t             ent [ENTRIES];
    entry_t             new_ent;
    logic [ENTRIES-1:0] hit1, hit2, rdy;
    logic               sel_ok;
    logic [AW-1:0]      sel_idx, sel_age, free_idx;
    logic [DATA_W-1:0]  sel_a, sel_b;
    logic               load, do_free, do_disp;

    assign in_ready = (count != CW'(ENTRIES));
    assign load     = !iss_valid || iss_ready;
    assign do_free  = load && sel_ok;
    assign do_disp  = in_valid && in_ready && !flush;

    always_comb begin
        hit1     = '0;
        hit2     = '0;
        rdy      = '0;
        sel_ok   = 1'b0;
        sel_idx  = '0;
        sel_age  = '1;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit1[i] = wb_valid && ent[i].tag1 != TAG_INVALID && ent[i].tag1 == wb_tag;
            hit2[i] = wb_valid && ent[i].tag2 != TAG_INVALID && ent[i].tag2 == wb_tag;
`ifdef RS_FAST_WAKEUP_EN
            rdy[i]  = ent[i].busy && (ent[i].tag1 == TAG_INVALID || hit1[i])
                                  && (ent[i].tag2 == TAG_INVALID || hit2[i]);
`else
            rdy[i]  = ent[i].busy && ent[i].tag1 == TAG_INVALID && ent[i].tag2 == TAG_INVALID;
`endif
            if (rdy[i] && (!sel_ok || ent[i].age < sel_age)) begin
                sel_ok  = 1'b1;
                sel_idx = AW'(i);
                sel_age = ent[i].age;
            end
        end
        for (int i = ENTRIES-1; i >= 0; i--)
            if (!ent[i].busy) free_idx = AW'(i);
    end

    always_comb begin
        sel_a = ent[sel_idx].val1;
        sel_b = ent[sel_idx].val2;
`ifdef RS_FAST_WAKEUP_EN
        // operands arriving on this broadcast bypass the entry storage
        if (hit1[sel_idx]) sel_a = wb_data;
        if (hit2[sel_idx]) sel_b = wb_data;
`endif
    end

    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = in_op;
        new_ent.dest = in_dest_tag;
        new_ent.tag1 = in_tag1;
        new_ent.val1 = in_val1;
        new_ent.tag2 = in_tag2;
        new_ent.val2 = in_val2;
        if (wb_valid && in_tag1 != TAG_INVALID && in_tag1 == wb_tag) begin
            new_ent.tag1 = TAG_INVALID;
            new_ent.val1 = wb_data;
        end
        if (wb_valid && in_tag2 != TAG_INVALID && in_tag2 == wb_tag) begin
            new_ent.tag2 = TAG_INVALID;
            new_ent.val2 = wb_data;
        end
        new_ent.age = AW'(count - CW'(do_free));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
            iss_valid    <= 1'b0;
            iss_op       <= '0;
            iss_dest_tag <= '0;
            iss_a        <= '0;
            iss_b        <= '0;
            count        <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) ent[i].busy <= 1'b0;
            iss_valid <= 1'b0;
            count     <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ent[i].busy) begin
                    if (hit1[i]) begin
                        ent[i].tag1 <= TAG_INVALID;
                        ent[i].val1 <= wb_data;
                    end
                    if (hit2[i]) begin
                        ent[i].tag2 <= TAG_INVALID;
                        ent[i].val2 <= wb_data;
                    end
                    if (do_free && ent[i].age > sel_age) ent[i].age <= ent[i].age - AW'(1);
                end
            end
            if (do_free) ent[sel_idx].busy <= 1'b0;
            if (do_disp) ent[free_idx] <= new_ent;
            if (load) begin
                iss_valid <= sel_ok;
                if (sel_ok) begin
                    iss_op       <= ent[sel_idx].op;
                    iss_dest_tag <= ent[sel_idx].dest;
                    iss_a        <= sel_a;
                    iss_b        <= sel_b;
                end
            end
            count <= count + CW'(do_disp) - CW'(do_free);
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_alu_rs;
    localparam int DATA_W = 32, TAG_W = 4, OP_W = 5, ENTRIES = 4;
    localparam logic [TAG_W-1:0] TI = '1;
`ifdef RS_FAST_WAKEUP_EN
    localparam int WK = 1;
`else
    localparam int WK = 2;
`endif

    logic clk = 0, rst = 0, flush = 0, in_valid = 0, wb_valid = 0, iss_ready = 1;
    logic in_ready, iss_valid;
    logic [OP_W-1:0]   in_op = '0, iss_op;
    logic [TAG_W-1:0]  in_dest_tag = '0, in_tag1 = TI, in_tag2 = TI, wb_tag = '0, iss_dest_tag;
    logic [DATA_W-1:0] in_val1 = '0, in_val2 = '0, wb_data = '0, iss_a, iss_b;
    logic [2:0]        count;

    alu_rs #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dest_tag(in_dest_tag), .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_val1(in_val1), .in_val2(in_val2), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .wb_data(wb_data), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_dest_tag(iss_dest_tag), .iss_a(iss_a), .iss_b(iss_b), .count(count));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // model: queue in dispatch order, head is oldest
    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest, t1, t2;
        logic [DATA_W-1:0] v1, v2;
    } ent_t;
    ent_t q[$];
    logic              m_iv = 0;
    logic [OP_W-1:0]   m_op = '0;
    logic [TAG_W-1:0]  m_dest = '0;
    logic [DATA_W-1:0] m_a = '0, m_b = '0;

    function automatic bit can_issue(ent_t e);
`ifdef RS_FAST_WAKEUP_EN
        return (e.t1 == TI || (wb_valid && e.t1 == wb_tag)) &&
               (e.t2 == TI || (wb_valid && e.t2 == wb_tag));
`else
        return e.t1 == TI && e.t2 == TI;
`endif
    endfunction

    task automatic model_edge();
        bit disp_ok;
        int k;
        ent_t e;
        if (!rst || flush) begin
            q.delete();
            m_iv = 0;
            return;
        end
        disp_ok = in_valid && (q.size() != ENTRIES);
        if (!m_iv || iss_ready) begin
            k = -1;
            foreach (q[i]) if (k < 0 && can_issue(q[i])) k = i;
            m_iv = (k >= 0);
            if (k >= 0) begin
                m_op   = q[k].op;
                m_dest = q[k].dest;
                m_a    = (q[k].t1 == TI) ? q[k].v1 : wb_data;
                m_b    = (q[k].t2 == TI) ? q[k].v2 : wb_data;
                q.delete(k);
            end
        end
        foreach (q[i]) begin
            if (wb_valid && q[i].t1 != TI && q[i].t1 == wb_tag) begin q[i].t1 = TI; q[i].v1 = wb_data; end
            if (wb_valid && q[i].t2 != TI && q[i].t2 == wb_tag) begin q[i].t2 = TI; q[i].v2 = wb_data; end
        end
        if (disp_ok) begin
            e = '{op: in_op, dest: in_dest_tag, t1: in_tag1, t2: in_tag2, v1: in_val1, v2: in_val2};
            if (wb_valid && e.t1 != TI && e.t1 == wb_tag) begin e.t1 = TI; e.v1 = wb_data; end
            if (wb_valid && e.t2 != TI && e.t2 == wb_tag) begin e.t2 = TI; e.v2 = wb_data; end
            q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                            input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                            input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
        in_valid = 1; in_op = op; in_dest_tag = dest;
        in_tag1 = t1; in_val1 = v1; in_tag2 = t2; in_val2 = v2;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        total++;
        if ({iss_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            bad++; $display("FAIL reset_ctrl got=%b want=%b", {iss_valid, count, in_ready}, 5'b00001);
        end
        total++;
        if ({iss_op, iss_dest_tag, iss_a, iss_b} !== '0) begin
            bad++; $display("FAIL reset_data got op=%0h dest=%0h a=%0h b=%0h want all 0",
                            iss_op, iss_dest_tag, iss_a, iss_b);
        end
        rst = 1;
    endtask

    task automatic test_basic();
        set_disp(5'd3, 4'd2, TI, 32'd5, TI, 32'd7);
        cyc();
        in_valid = 0;
        total++;
        if ({iss_valid, count} !== {1'b0, 3'd1}) begin
            bad++; $display("FAIL basic_e0 got v=%b cnt=%0d want v=0 cnt=1", iss_valid, count);
        end
        cyc();
        total++;
        if ({iss_valid, iss_op, iss_dest_tag, iss_a, iss_b, count} !== {1'b1, 5'd3, 4'd2, 32'd5, 32'd7, 3'd0}) begin
            bad++; $display("FAIL basic_issue got v=%b op=%0d d=%0d a=%0h b=%0h cnt=%0d want 1 3 2 5 7 0",
                            iss_valid, iss_op, iss_dest_tag, iss_a, iss_b, count);
        end
        cyc();
        total++;
        if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got v=%b want 0", iss_valid); end
    endtask

    task automatic test_wakeup();
        set_disp(5'd4, 4'd3, 4'd4, 32'd0, TI, 32'h11);
        cyc();
        in_valid = 0;
        cyc();
        total++;
        if ({iss_valid, count} !== {1'b0, 3'd1}) begin
            bad++; $display("FAIL wake_wait got v=%b cnt=%0d want v=0 cnt=1", iss_valid, count);
        end
        wb_valid = 1; wb_tag = 4'd4; wb_data = 32'h1234;
        for (int k = 1; k <= WK; k++) begin
            cyc();
            wb_valid = 0;
            if (k < WK) begin
                total++;
                if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_early got v=%b want 0", iss_valid); end
            end
        end
        total++;
        if ({iss_valid, iss_dest_tag, iss_a, iss_b} !== {1'b1, 4'd3, 32'h1234, 32'h11}) begin
            bad++; $display("FAIL wake_issue got v=%b d=%0d a=%0h b=%0h want 1 3 1234 11",
                            iss_valid, iss_dest_tag, iss_a, iss_b);
        end
        cyc();
    endtask

    task automatic test_bypass();
        set_disp(5'd5, 4'd5, TI, 32'd1, 4'd6, 32'd0);
        wb_valid = 1; wb_tag = 4'd6; wb_data = 32'd9;
        cyc();
        in_valid = 0; wb_valid = 0;
        cyc();
        total++;
        if ({iss_valid, iss_dest_tag, iss_a, iss_b} !== {1'b1, 4'd5, 32'd1, 32'd9}) begin
            bad++; $display("FAIL bypass got v=%b d=%0d a=%0h b=%0h want 1 5 1 9",
                            iss_valid, iss_dest_tag, iss_a, iss_b);
        end
        cyc();
    endtask

    task automatic test_full();
        iss_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_disp(5'(i + 1), 4'(8 + i), 4'd5, 32'd0, TI, 32'(i));
            cyc();
        end
        set_disp(5'd9, 4'd15, TI, 32'd3, TI, 32'd4);
        total++;
        if ({count, in_ready} !== {3'd4, 1'b0}) begin
            bad++; $display("FAIL full_ready got cnt=%0d rdy=%b want 4 0", count, in_ready);
        end
        cyc();
        in_valid = 0;
        total++;
        if ({count, iss_valid} !== {3'd4, 1'b0}) begin
            bad++; $display("FAIL full_ignore got cnt=%0d v=%b want 4 0", count, iss_valid);
        end
        wb_valid = 1; wb_tag = 4'd5; wb_data = 32'hAA;
        for (int k = 1; k <= WK; k++) begin cyc(); wb_valid = 0; end
        for (int s = 0; s < 4; s++) begin
            total++;
            if ({iss_valid, iss_op, iss_dest_tag, iss_a, iss_b, count} !== {1'b1, 5'd1, 4'd8, 32'hAA, 32'd0, 3'd3}) begin
                bad++; $display("FAIL stall_hold%0d got v=%b op=%0d d=%0d a=%0h b=%0h cnt=%0d want 1 1 8 aa 0 3",
                                s, iss_valid, iss_op, iss_dest_tag, iss_a, iss_b, count);
            end
            if (s < 3) cyc();
        end
        iss_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            total++;
            if ({iss_valid, iss_dest_tag, iss_a, iss_b, count} !== {1'b1, 4'(8 + k), 32'hAA, 32'(k), 3'(3 - k)}) begin
                bad++; $display("FAIL order%0d got v=%b d=%0d a=%0h b=%0h cnt=%0d want d=%0d",
                                k, iss_valid, iss_dest_tag, iss_a, iss_b, count, 8 + k);
            end
        end
        cyc();
        total++;
        if ({iss_valid, count} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL full_drain got v=%b cnt=%0d want 0 0", iss_valid, count);
        end
    endtask

    task automatic test_age();
        set_disp(5'd6, 4'd1, 4'd1, 32'd0, TI, 32'h21);
        cyc();
        set_disp(5'd7, 4'd2, TI, 32'h31, TI, 32'h32);
        cyc();
        in_valid = 0;
        cyc();
        total++;
        if ({iss_valid, iss_dest_tag, iss_a, iss_b, count} !== {1'b1, 4'd2, 32'h31, 32'h32, 3'd1}) begin
            bad++; $display("FAIL age_b got v=%b d=%0d a=%0h b=%0h cnt=%0d want 1 2 31 32 1",
                            iss_valid, iss_dest_tag, iss_a, iss_b, count);
        end
        wb_valid = 1; wb_tag = 4'd1; wb_data = 32'h77;
        for (int k = 1; k <= WK; k++) begin
            cyc();
            wb_valid = 0;
            if (k < WK) begin
                total++;
                if (iss_valid !== 1'b0) begin bad++; $display("FAIL age_gap got v=%b want 0", iss_valid); end
            end
        end
        total++;
        if ({iss_valid, iss_dest_tag, iss_a, iss_b, count} !== {1'b1, 4'd1, 32'h77, 32'h21, 3'd0}) begin
            bad++; $display("FAIL age_a got v=%b d=%0d a=%0h b=%0h cnt=%0d want 1 1 77 21 0",
                            iss_valid, iss_dest_tag, iss_a, iss_b, count);
        end
        cyc();
    endtask

    task automatic test_flush();
        iss_ready = 0;
        set_disp(5'd1, 4'd1, TI, 32'd10, TI, 32'd11); cyc();
        set_disp(5'd2, 4'd2, TI, 32'd20, TI, 32'd21); cyc();
        set_disp(5'd3, 4'd3, 4'd7, 32'd0, TI, 32'd31); cyc();
        set_disp(5'd4, 4'd4, TI, 32'd40, 4'd7, 32'd0); cyc();
        total++;
        if ({count, iss_valid, iss_dest_tag} !== {3'd3, 1'b1, 4'd1}) begin
            bad++; $display("FAIL flush_pre got cnt=%0d v=%b d=%0d want 3 1 1", count, iss_valid, iss_dest_tag);
        end
        flush = 1;
        set_disp(5'd5, 4'd13, TI, 32'd50, TI, 32'd51);
        wb_valid = 1; wb_tag = 4'd7; wb_data = 32'h99;
        cyc();
        flush = 0; in_valid = 0; wb_valid = 0;
        total++;
        if ({count, iss_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL flush_clear got cnt=%0d v=%b rdy=%b want 0 0 1", count, iss_valid, in_ready);
        end
        iss_ready = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++;
            if ({iss_valid, count} !== {1'b0, 3'd0}) begin
                bad++; $display("FAIL flush_ghost%0d got v=%b d=%0d cnt=%0d want v=0 cnt=0",
                                k, iss_valid, iss_dest_tag, count);
            end
        end
    endtask

    task automatic test_random();
        flush = 1; cyc(); flush = 0;
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(0, 2) != 0);
            in_op       = OP_W'($urandom);
            in_dest_tag = TAG_W'($urandom);
            in_tag1     = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 5)) : TI;
            in_tag2     = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 5)) : TI;
            in_val1     = $urandom;
            in_val2     = $urandom;
            wb_valid    = ($urandom_range(0, 9) < 4);
            wb_tag      = TAG_W'($urandom_range(0, 6));
            wb_data     = $urandom;
            iss_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            cyc();
            total++;
            if ({iss_valid, count, in_ready} !== {m_iv, 3'(q.size()), q.size() != ENTRIES}) begin
                bad++; $display("FAIL rnd_ctrl@%0d got v=%b cnt=%0d rdy=%b want v=%b cnt=%0d",
                                n, iss_valid, count, in_ready, m_iv, q.size());
            end
            if (m_iv) begin
                total++;
                if ({iss_op, iss_dest_tag, iss_a, iss_b} !== {m_op, m_dest, m_a, m_b}) begin
                    bad++; $display("FAIL rnd_data@%0d got op=%0h d=%0h a=%0h b=%0h want op=%0h d=%0h a=%0h b=%0h",
                                    n, iss_op, iss_dest_tag, iss_a, iss_b, m_op, m_dest, m_a, m_b);
                end
            end
        end
        in_valid = 0; wb_valid = 0; flush = 0; iss_ready = 1;
    endtask

    task automatic test_async_reset();
        set_disp(5'd1, 4'd1, TI, 32'd1, TI, 32'd2); cyc();
        set_disp(5'd2, 4'd2, 4'd3, 32'd1, TI, 32'd2); cyc();
        in_valid = 0;
        #2 rst = 0;
        #1;
        total++;
        if ({iss_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            bad++; $display("FAIL async_reset got v=%b cnt=%0d rdy=%b want 0 0 1", iss_valid, count, in_ready);
        end
        q.delete();
        m_iv = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_age();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
